// File: rtl/kianv_timer_pkg.sv
// Shared types for the timer block.
// Mode and state encodings used by the counter and its bench.
package kianv_timer_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_SAT      = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_PERIODIC = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/clk_prescaler.sv
// Prescaler: one tick every psc+1 enabled cycles.
// tick is combinational in the cycle the count reaches psc.
module clk_prescaler #(
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PSC_WIDTH-1:0] psc,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] r_cnt;
    logic                 w_hit;

    // >= so that lowering psc mid-run cannot strand the count above it
    assign w_hit = (r_cnt >= psc);
    assign tick  = en && w_hit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_hit ? '0 : r_cnt + PSC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Up/down timer with wrap, saturate, one-shot and periodic modes.
// Count and state update on prescaler ticks; clr > load > step.
import kianv_timer_pkg::*;

module timer_counter #(
    parameter int               WIDTH     = 32,
    parameter int               PSC_WIDTH = 8,
    parameter logic [WIDTH-1:0] PRESET    = '0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 dir,
    input  logic [1:0]           mode,
    input  logic [PSC_WIDTH-1:0] psc,
    input  logic [WIDTH-1:0]     cmp,
    output logic [WIDTH-1:0]     q,
    output logic                 tick,
    output logic                 match,
    output logic                 wrap,
    output logic                 done,
    output logic                 busy
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    state_e           r_state;
    logic             r_match;
    logic             r_wrap;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    state_e           w_state_nxt;
    logic             w_match_nxt;
    logic             w_wrap_nxt;

    logic             w_ctl;
    logic             w_run_en;
    logic             w_tick;
    logic             w_edge;
    logic [WIDTH-1:0] w_stepv;
    mode_e            w_mode;

    // reset, clr and load all suppress stepping and pulses this cycle
    assign w_ctl    = clr || load || !resetn;
    assign w_run_en = (r_state == RUN) && en && !w_ctl;
    assign w_mode   = mode_e'(mode);
    assign w_edge   = dir ? (r_q == '0) : (&r_q);
    assign w_stepv  = dir ? r_q - WIDTH'(1) : r_q + WIDTH'(1);

    clk_prescaler #(
        .PSC_WIDTH(PSC_WIDTH)
    ) u_psc (
        .clk   (clk),
        .resetn(resetn),
        .en    (w_run_en),
        .clr   (w_ctl),
        .psc   (psc),
        .tick  (w_tick)
    );

    always_comb begin
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_state_nxt  = r_state;
        w_match_nxt  = 1'b0;
        w_wrap_nxt   = 1'b0;
        if (clr) begin
            w_q_nxt     = '0;
            w_state_nxt = IDLE;
        end else if (load) begin
            w_q_nxt      = load_val;
            w_reload_nxt = load_val;
            w_state_nxt  = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (en) w_state_nxt = RUN;
                end
                RUN: begin
                    if (!en) begin
                        w_state_nxt = IDLE;
                    end else if (w_tick) begin
                        unique case (w_mode)
                            MODE_WRAP: begin
                                w_q_nxt    = w_stepv;
                                w_wrap_nxt = w_edge;
                            end
                            MODE_SAT: begin
                                w_q_nxt = w_edge ? r_q : w_stepv;
                            end
                            MODE_ONESHOT: begin
                                w_q_nxt = w_stepv;
                                if (w_stepv == cmp) w_state_nxt = DONE;
                            end
                            MODE_PERIODIC: begin
                                if (r_q == cmp) begin
                                    w_q_nxt    = r_reload;
                                    w_wrap_nxt = 1'b1;
                                end else begin
                                    w_q_nxt = w_stepv;
                                end
                            end
                        endcase
                        // a step that leaves q unchanged is not a new arrival
                        w_match_nxt = (w_q_nxt == cmp) && (w_q_nxt != r_q);
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_q      <= PRESET;
            r_reload <= PRESET;
            r_state  <= IDLE;
            r_match  <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_state  <= w_state_nxt;
            r_match  <= w_match_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign q     = r_q;
    assign tick  = w_tick;
    assign match = r_match && !w_ctl;
    assign wrap  = r_wrap && !w_ctl;
    assign done  = (r_state == DONE);
    assign busy  = (r_state == RUN);

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: each step's q/wrap/match is queued
// by the stimulus and popped by a monitor on the cycle after each tick.
module tb_timer_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] psc;
    logic [7:0] cmp;
    logic [7:0] q;
    logic       tick;
    logic       match;
    logic       wrap;
    logic       done;
    logic       busy;

    timer_counter #(
        .WIDTH    (8),
        .PSC_WIDTH(8),
        .PRESET   (8'd5)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .dir     (dir),
        .mode    (mode),
        .psc     (psc),
        .cmp     (cmp),
        .q       (q),
        .tick    (tick),
        .match   (match),
        .wrap    (wrap),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
        logic       match;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_tick = 1'b0;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endfunction

    function automatic void push(logic [7:0] qv, logic w, logic m);
        exp_t e;
        e.q     = qv;
        e.wrap  = w;
        e.match = m;
        exp_q.push_back(e);
    endfunction

    // monitor: a tick seen last negedge means q/pulses show the step now
    always @(negedge clk) begin
        exp_t e;
        if (prev_tick) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step", {q, wrap, match}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("step_q", q, e.q);
                check("step_wrap", wrap, e.wrap);
                check("step_match", match, e.match);
            end
        end else begin
            check("no_step_pulses", {wrap, match}, 2'b00);
        end
        prev_tick = tick;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        cyc();
        load     = 1'b0;
    endtask

    task automatic run(int n);
        en = 1'b1;
        repeat (n) cyc();
        en = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        dir      = 1'b0;
        mode     = 2'd0;
        psc      = 8'd0;
        cmp      = 8'h80;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_q", q, 8'd5);
        check("rst_flags", {tick, match, wrap, done, busy}, 5'b0);
        cyc();
        resetn = 1'b1;

        // wrap up through 0xFF
        do_load(8'hFE);
        push(8'hFF, 1'b0, 1'b0);
        push(8'h00, 1'b1, 1'b0);
        push(8'h01, 1'b0, 1'b0);
        run(4);

        // prescaler psc=3: tick on every 4th running cycle
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        psc = 8'd3;
        push(8'd1, 1'b0, 1'b0);
        push(8'd2, 1'b0, 1'b0);
        push(8'd3, 1'b0, 1'b0);
        en = 1'b1;
        cyc();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("psc_tick", tick, (i % 4) == 3);
            cyc();
        end
        en = 1'b0;
        @(negedge clk);
        check("psc_q12", q, 8'd3);
        cyc();
        psc = 8'd0;

        // one-shot down 10 -> 7, then hold in DONE
        mode = 2'd2;
        dir  = 1'b1;
        cmp  = 8'd7;
        do_load(8'd10);
        push(8'd9, 1'b0, 1'b0);
        push(8'd8, 1'b0, 1'b0);
        push(8'd7, 1'b0, 1'b1);
        en = 1'b1;
        repeat (4) cyc();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0)
                check("oneshot_hold", {q, done, busy, tick},
                      {8'd7, 1'b1, 1'b0, 1'b0});
            cyc();
        end
        en  = 1'b0;
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        @(negedge clk);
        check("clr_done", {q, done}, {8'd0, 1'b0});
        cyc();

        // periodic 2..5
        mode = 2'd3;
        dir  = 1'b0;
        cmp  = 8'd5;
        do_load(8'd2);
        for (int p = 0; p < 2; p++) begin
            push(8'd3, 1'b0, 1'b0);
            push(8'd4, 1'b0, 1'b0);
            push(8'd5, 1'b0, 1'b1);
            push(8'd2, 1'b1, 1'b0);
        end
        run(9);

        // saturate down at 0, ticks continue
        mode = 2'd1;
        dir  = 1'b1;
        cmp  = 8'h80;
        do_load(8'd1);
        repeat (4) push(8'd0, 1'b0, 1'b0);
        run(5);

        // wrap down through 0
        mode = 2'd0;
        do_load(8'd0);
        push(8'hFF, 1'b1, 1'b0);
        push(8'hFE, 1'b0, 1'b0);
        run(3);

        // clr and load together mid-run
        dir = 1'b0;
        do_load(8'h40);
        push(8'h41, 1'b0, 1'b0);
        push(8'h42, 1'b0, 1'b0);
        en = 1'b1;
        repeat (3) cyc();
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 8'h33;
        @(negedge clk);
        check("ctl_no_pulse", {tick, match, wrap}, 3'b0);
        cyc();
        clr  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        check("clr_over_load", {q, busy}, {8'd0, 1'b0});
        cyc();

        // reset mid-run
        do_load(8'h10);
        push(8'h11, 1'b0, 1'b0);
        push(8'h12, 1'b0, 1'b0);
        en = 1'b1;
        repeat (3) cyc();
        resetn = 1'b0;
        @(negedge clk);
        check("rst_run_tick", tick, 1'b0);
        cyc();
        resetn = 1'b1;
        en     = 1'b0;
        @(negedge clk);
        check("rst_run_q", q, 8'd5);
        check("rst_run_flags", {tick, match, wrap, done, busy}, 5'b0);
        cyc();

        // reset in DONE overrides a simultaneous load
        mode = 2'd2;
        cmp  = 8'd2;
        do_load(8'd0);
        push(8'd1, 1'b0, 1'b0);
        push(8'd2, 1'b0, 1'b1);
        en = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        check("done_set", {done, busy}, 2'b10);
        cyc();
        resetn   = 1'b0;
        load     = 1'b1;
        load_val = 8'h77;
        cyc();
        resetn = 1'b1;
        load   = 1'b0;
        en     = 1'b0;
        @(negedge clk);
        check("rst_done_q", q, 8'd5);
        check("rst_done_flags", {done, busy}, 2'b00);
        cyc();

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
